// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM state types for the AXI burst RAM slave.
//   BURST_*    : AxBURST encodings
//   RESP_*     : xRESP encodings
//   r_state_e  : read channel FSM states
//   w_state_e  : write channel FSM states
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {RIdle, RBurst} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat address generator and burst legality check.
// Optional feature macro: AXI_RAM_WRAP_BURST_EN enables WRAP bursts.
//   addr_i      : current beat address (already aligned to the bus width)
//   len_i       : AxLEN (beats-1)
//   size_i      : AxSIZE
//   burst_i     : AxBURST
//   next_addr_o : address of the following beat
//   err_o       : burst is illegal for this RAM, whole burst answers SLVERR
module axi_burst_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [7:0]               len_i,
  input  logic [2:0]               size_i,
  input  logic [1:0]               burst_i,
  output logic [ADDRESS_WIDTH-1:0] next_addr_o,
  output logic                     err_o
);

  localparam int unsigned            Bytes    = DATA_WIDTH / 8;
  localparam logic [2:0]             SizeLog2 = 3'($clog2(Bytes));
  localparam logic [ADDRESS_WIDTH-1:0] Step   = ADDRESS_WIDTH'(Bytes);

`ifdef AXI_RAM_WRAP_BURST_EN
  logic [ADDRESS_WIDTH-1:0] wrap_mask;
  logic                     wrap_len_ok;

  always_comb begin
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    // Window size is beats*Bytes; a power of two whenever the length is legal.
    wrap_mask   = ADDRESS_WIDTH'(((32'(len_i) + 32'd1) * Bytes) - 32'd1);
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_addr_o = addr_i;
    err_o       = (size_i != SizeLog2);
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      // Natural overflow wraps at the top of the RAM.
      BURST_INCR:  next_addr_o = addr_i + Step;
`ifdef AXI_RAM_WRAP_BURST_EN
      BURST_WRAP: begin
        next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + Step) & wrap_mask);
        if (!wrap_len_ok) err_o = 1'b1;
      end
`endif
      default:     err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram_slave.sv
// AXI4 slave RAM with independent read and write channels, 1 beat/clock.
// Optional feature macro: AXI_RAM_WRAP_BURST_EN enables WRAP bursts (else SLVERR).
//   aclk/aresetn                      : clock, async active-low reset
//   aw*/w*/b*                          : write address, data and response channels
//   ar*/r*                             : read address and data channels
// Illegal bursts run to completion with SLVERR on every beat, no RAM write, rdata=0.
module axi_burst_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Offs  = $clog2(Bytes);
  localparam int unsigned Depth = 2 ** (ADDRESS_WIDTH - Offs);
  localparam logic [ADDRESS_WIDTH-1:0] AlignMask = ~ADDRESS_WIDTH'(Bytes - 1);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // ---------------- Read channel ----------------
  r_state_e                 r_state_q;
  logic [ADDRESS_WIDTH-1:0] raddr_q;
  logic [7:0]               rlen_q, rcnt_q;
  logic [2:0]               rsize_q;
  logic [1:0]               rburst_q;

  logic [ADDRESS_WIDTH-1:0] rg_addr, rg_next;
  logic [7:0]               rg_len;
  logic [2:0]               rg_size;
  logic [1:0]               rg_burst;
  logic                     rg_err;
  logic [ADDRESS_WIDTH-Offs-1:0] rd_idx;

  // While idle the generator checks the incoming request; during a burst it steps it.
  always_comb begin
    if (r_state_q == RIdle) begin
      rg_addr  = araddr & AlignMask;
      rg_len   = arlen;
      rg_size  = arsize;
      rg_burst = arburst;
    end else begin
      rg_addr  = raddr_q;
      rg_len   = rlen_q;
      rg_size  = rsize_q;
      rg_burst = rburst_q;
    end
  end

  axi_burst_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_rd_addr_gen (
    .addr_i      (rg_addr),
    .len_i       (rg_len),
    .size_i      (rg_size),
    .burst_i     (rg_burst),
    .next_addr_o (rg_next),
    .err_o       (rg_err)
  );

  // Word to present on the next R beat: first beat when idle, following beat otherwise.
  assign rd_idx = (r_state_q == RIdle) ? rg_addr[ADDRESS_WIDTH-1:Offs]
                                       : rg_next[ADDRESS_WIDTH-1:Offs];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= RIdle;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= RESP_OKAY;
      rdata     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (arvalid) begin
            r_state_q <= RBurst;
            arready   <= 1'b0;
            rvalid    <= 1'b1;
            raddr_q   <= rg_addr;
            rlen_q    <= arlen;
            rsize_q   <= arsize;
            rburst_q  <= arburst;
            rcnt_q    <= '0;
            rlast     <= (arlen == 8'd0);
            rresp     <= rg_err ? RESP_SLVERR : RESP_OKAY;
            rdata     <= rg_err ? '0 : mem_q[rd_idx];
          end
        end
        RBurst: begin
          if (rready) begin
            if (rlast) begin
              r_state_q <= RIdle;
              arready   <= 1'b1;
              rvalid    <= 1'b0;
              rlast     <= 1'b0;
            end else begin
              raddr_q <= rg_next;
              rcnt_q  <= rcnt_q + 8'd1;
              rlast   <= ((rcnt_q + 8'd1) == rlen_q);
              rdata   <= rg_err ? '0 : mem_q[rd_idx];
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // ---------------- Write channel ----------------
  w_state_e                 w_state_q;
  logic [ADDRESS_WIDTH-1:0] waddr_q;
  logic [7:0]               wlen_q, wcnt_q;
  logic [2:0]               wsize_q;
  logic [1:0]               wburst_q;
  logic                     wlast_err_q;

  logic [ADDRESS_WIDTH-1:0] wg_addr, wg_next;
  logic [7:0]               wg_len;
  logic [2:0]               wg_size;
  logic [1:0]               wg_burst;
  logic                     wg_err;

  always_comb begin
    if (w_state_q == WIdle) begin
      wg_addr  = awaddr & AlignMask;
      wg_len   = awlen;
      wg_size  = awsize;
      wg_burst = awburst;
    end else begin
      wg_addr  = waddr_q;
      wg_len   = wlen_q;
      wg_size  = wsize_q;
      wg_burst = wburst_q;
    end
  end

  axi_burst_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_wr_addr_gen (
    .addr_i      (wg_addr),
    .len_i       (wg_len),
    .size_i      (wg_size),
    .burst_i     (wg_burst),
    .next_addr_o (wg_next),
    .err_o       (wg_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q   <= WIdle;
      awready     <= 1'b1;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      wsize_q     <= '0;
      wburst_q    <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (awvalid) begin
            w_state_q   <= WData;
            awready     <= 1'b0;
            wready      <= 1'b1;
            waddr_q     <= wg_addr;
            wlen_q      <= awlen;
            wsize_q     <= awsize;
            wburst_q    <= awburst;
            wcnt_q      <= '0;
            wlast_err_q <= 1'b0;
          end
        end
        WData: begin
          if (wvalid) begin
            if (wcnt_q == wlen_q) begin
              // Beat count, not wlast, ends the burst; a wlast mismatch only flags SLVERR.
              w_state_q <= WResp;
              wready    <= 1'b0;
              bvalid    <= 1'b1;
              bresp     <= (wg_err || wlast_err_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              waddr_q <= wg_next;
              wcnt_q  <= wcnt_q + 8'd1;
              if (wlast) wlast_err_q <= 1'b1;
            end
          end
        end
        WResp: begin
          if (bready) begin
            w_state_q <= WIdle;
            bvalid    <= 1'b0;
            awready   <= 1'b1;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Storage is never reset. A same-edge read samples the pre-write word.
  always_ff @(posedge aclk) begin
    if (wready && wvalid && !wg_err) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (wstrb[b]) mem_q[waddr_q[ADDRESS_WIDTH-1:Offs]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed self-checking bench for axi_burst_ram_slave (32-bit data, 256-byte RAM).
module tb_axi_burst_ram_slave;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

`ifdef AXI_RAM_WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, arvalid = 1'b0;
  logic          awready, arready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_burst_ram_slave #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .aclk    (aclk),    .aresetn (aresetn),
    .awaddr  (awaddr),  .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst),
    .awvalid (awvalid), .awready (awready),
    .wdata   (wdata),   .wstrb   (wstrb),   .wlast   (wlast),
    .wvalid  (wvalid),  .wready  (wready),
    .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
    .araddr  (araddr),  .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst),
    .arvalid (arvalid), .arready (arready),
    .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
    .rvalid  (rvalid),  .rready  (rready)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [1:0]  resp;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one write burst from wd/ws; early >= 0 also raises wlast on that beat.
  task automatic axi_write(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input int early, output logic [1:0] bresp_o);
    int n;
    @(negedge aclk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check_eq("awready_wait", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == int'(len)) || (b == early); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) check_eq("wready_wait", 32'(wready), 32'd1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check_eq("bvalid_wait", 32'(bvalid), 32'd1);
    bresp_o = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // Collects one read burst into rd/rr/rl; toggle alternates rready 0/1 and checks hold.
  task automatic axi_read(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input bit toggle);
    int          n, beat, cyc;
    logic [31:0] hold_d;
    logic        hold_l;
    bit          holding;
    @(negedge aclk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check_eq("arready_wait", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("rvalid_t1", 32'(rvalid), 32'd1);
    beat = 0; cyc = 0; holding = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beat <= int'(len) && cyc < 100) begin
      rready = !toggle || (cyc % 2 == 1);
      if (holding) begin
        check_eq("r_hold_data", rdata, hold_d);
        check_eq("r_hold_last", 32'(rlast), 32'(hold_l));
        holding = 1'b0;
      end
      if (rvalid && rready) begin
        rd[beat] = rdata; rr[beat] = rresp; rl[beat] = rlast; beat++;
      end else if (rvalid) begin
        hold_d = rdata; hold_l = rlast; holding = 1'b1;
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) check_eq("r_beats", 32'(beat), 32'(int'(len) + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;
    repeat (3) @(negedge aclk);
    check_eq("rst_awready", 32'(awready), 32'd1);
    check_eq("rst_arready", 32'(arready), 32'd1);
    check_eq("rst_wready",  32'(wready),  32'd0);
    check_eq("rst_bvalid",  32'(bvalid),  32'd0);
    check_eq("rst_rvalid",  32'(rvalid),  32'd0);
    check_eq("rst_rlast",   32'(rlast),   32'd0);
    check_eq("rst_rdata",   rdata,        32'd0);
    check_eq("rst_rresp",   32'(rresp),   32'd0);
    check_eq("rst_bresp",   32'(bresp),   32'd0);
    aresetn = 1'b1;

    // Single-beat INCR
    wd[0] = 32'hDEADBEEF;
    axi_write(8'h10, 8'd0, 2'b01, 3'd2, -1, resp);
    check_eq("single_bresp", 32'(resp), 32'd0);
    axi_read(8'h10, 8'd0, 2'b01, 3'd2, 1'b0);
    check_eq("single_rdata", rd[0], 32'hDEADBEEF);
    check_eq("single_rresp", 32'(rr[0]), 32'd0);
    check_eq("single_rlast", 32'(rl[0]), 32'd1);

    // 4-beat INCR, read back with rready toggling
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    axi_write(8'h20, 8'd3, 2'b01, 3'd2, -1, resp);
    check_eq("incr4_bresp", 32'(resp), 32'd0);
    axi_read(8'h20, 8'd3, 2'b01, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("incr4_d%0d", i), rd[i], 32'(i + 1));
      check_eq($sformatf("incr4_l%0d", i), 32'(rl[i]), 32'(i == 3));
    end

    // Byte strobes
    wd[0] = 32'h11223344;
    axi_write(8'h30, 8'd0, 2'b01, 3'd2, -1, resp);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h3;
    axi_write(8'h30, 8'd0, 2'b01, 3'd2, -1, resp);
    ws[0] = 4'hF;
    axi_read(8'h30, 8'd0, 2'b01, 3'd2, 1'b0);
    check_eq("strb_rdata", rd[0], 32'h1122CCDD);

    // FIXED: both beats land on the same word, unaligned start address
    wd[0] = 32'h5; wd[1] = 32'h6;
    axi_write(8'h52, 8'd1, 2'b00, 3'd2, -1, resp);
    check_eq("fixed_bresp", 32'(resp), 32'd0);
    axi_read(8'h50, 8'd0, 2'b01, 3'd2, 1'b0);
    check_eq("fixed_rdata", rd[0], 32'h6);

    // WRAP len=3 @0x08 over a known background
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0000000 + 32'(i);
    axi_write(8'h00, 8'd3, 2'b01, 3'd2, -1, resp);
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0000000 + 32'(i);
    axi_write(8'h08, 8'd3, 2'b10, 3'd2, -1, resp);
    check_eq("wrap_bresp", 32'(resp), WrapEn ? 32'd0 : 32'd2);
    axi_read(8'h00, 8'd3, 2'b01, 3'd2, 1'b0);
    check_eq("wrap_mem0", rd[0], WrapEn ? 32'hB0000002 : 32'hA0000000);
    check_eq("wrap_mem1", rd[1], WrapEn ? 32'hB0000003 : 32'hA0000001);
    check_eq("wrap_mem2", rd[2], WrapEn ? 32'hB0000000 : 32'hA0000002);
    check_eq("wrap_mem3", rd[3], WrapEn ? 32'hB0000001 : 32'hA0000003);
    axi_read(8'h08, 8'd3, 2'b10, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wrap_rd%0d", i), rd[i], WrapEn ? 32'hB0000000 + 32'(i) : 32'd0);
      check_eq($sformatf("wrap_rr%0d", i), 32'(rr[i]), WrapEn ? 32'd0 : 32'd2);
    end
    // WRAP with length 3 beats is never legal
    axi_read(8'h08, 8'd2, 2'b10, 3'd2, 1'b0);
    check_eq("wrap_len2_rr", 32'(rr[0]), 32'd2);
    check_eq("wrap_len2_rl", 32'(rl[2]), 32'd1);

    // Wrong size: SLVERR, zero data
    axi_read(8'h10, 8'd1, 2'b01, 3'd1, 1'b0);
    check_eq("size_rr0", 32'(rr[0]), 32'd2);
    check_eq("size_rr1", 32'(rr[1]), 32'd2);
    check_eq("size_rd0", rd[0], 32'd0);
    check_eq("size_rd1", rd[1], 32'd0);
    check_eq("size_rl0", 32'(rl[0]), 32'd0);
    check_eq("size_rl1", 32'(rl[1]), 32'd1);

    // Illegal writes leave RAM untouched
    wd[0] = 32'h12345678;
    axi_write(8'h10, 8'd0, 2'b01, 3'd1, -1, resp);
    check_eq("size_bresp", 32'(resp), 32'd2);
    axi_write(8'h10, 8'd0, 2'b11, 3'd2, -1, resp);
    check_eq("rsvd_bresp", 32'(resp), 32'd2);
    axi_read(8'h10, 8'd0, 2'b01, 3'd2, 1'b0);
    check_eq("illegal_keep", rd[0], 32'hDEADBEEF);

    // Early wlast: SLVERR but data written
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0000000 + 32'(i);
    axi_write(8'h40, 8'd3, 2'b01, 3'd2, 1, resp);
    check_eq("early_bresp", 32'(resp), 32'd2);
    axi_read(8'h40, 8'd3, 2'b01, 3'd2, 1'b0);
    check_eq("early_d1", rd[1], 32'hC0000001);
    check_eq("early_d3", rd[3], 32'hC0000003);

    // INCR across top of RAM wraps to 0
    wd[0] = 32'hE0E0E0E0; wd[1] = 32'hE1E1E1E1;
    axi_write(8'hFC, 8'd1, 2'b01, 3'd2, -1, resp);
    check_eq("top_bresp", 32'(resp), 32'd0);
    axi_read(8'hFC, 8'd1, 2'b01, 3'd2, 1'b0);
    check_eq("top_d0", rd[0], 32'hE0E0E0E0);
    check_eq("top_d1", rd[1], 32'hE1E1E1E1);

    // Reset in the middle of a read burst
    @(negedge aclk);
    araddr = 8'h20; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check_eq("mid_arready_wait", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    check_eq("mid_beat1", rdata, 32'd2);
    #2 aresetn = 1'b0;
    #1;
    check_eq("mid_rst_rvalid",  32'(rvalid),  32'd0);
    check_eq("mid_rst_arready", 32'(arready), 32'd1);
    check_eq("mid_rst_rdata",   rdata,        32'd0);
    rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    axi_read(8'h10, 8'd0, 2'b01, 3'd2, 1'b0);
    check_eq("post_rst_rdata", rd[0], 32'hDEADBEEF);
    check_eq("post_rst_rlast", 32'(rl[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
